// File: rtl/instruction_fetch_queue.sv
// Fetch stage: PC register, async instruction SRAM read, DEPTH-entry fetch FIFO to decode,
// branch/jump redirect with queue flush. Optional perf counters under `IF_PERF_CNT_EN.
module instruction_fetch_queue #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'h0040_0020)
) (
  input  logic                      clk,
  input  logic                      start_up,
  output logic [ADDR_W-1:0]         imem_addr,
  input  logic [31:0]               imem_rdata,
  input  logic                      redirect_valid,
  input  logic                      redirect_mode,
  input  logic [ADDR_W-1:0]         redirect_base,
  input  logic [25:0]               redirect_imm,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [31:0]               out_instr,
  output logic [ADDR_W-1:0]         out_pc,
  output logic [ADDR_W-1:0]         pc_out,
  output logic [$clog2(DEPTH):0]    q_count
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]               perf_fetched,
  output logic [31:0]               perf_flushed,
  output logic [31:0]               perf_stall
`endif
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] pc;
  logic [31:0]       instr_mem [DEPTH];
  logic [ADDR_W-1:0] pc_mem    [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  logic              pop_c;
  logic              full_c;
  logic              enq_c;
  logic [CNT_W-1:0]  count_next_c;
  logic [ADDR_W-1:0] seq_c;
  logic [ADDR_W-1:0] br_off_c;
  logic [ADDR_W-1:0] br_target_c;
  logic [ADDR_W-1:0] jmp_target_c;
  logic [ADDR_W-1:0] target_c;

  assign imem_addr = pc;
  assign pc_out    = pc;
  assign q_count   = count;
  assign out_instr = instr_mem[rd_ptr];
  assign out_pc    = pc_mem[rd_ptr];

  // Redirect target arithmetic; the jump keeps the region bits above bit 27 of base+4.
  assign seq_c       = redirect_base + ADDR_W'(4);
  assign br_off_c    = {{(ADDR_W - 18){redirect_imm[15]}}, redirect_imm[15:0], 2'b00};
  assign br_target_c = seq_c + br_off_c;

  generate
    if (ADDR_W > 28) begin : g_jmp_region
      assign jmp_target_c = {seq_c[ADDR_W-1:28], redirect_imm, 2'b00};
    end else begin : g_jmp_flat
      assign jmp_target_c = {redirect_imm, 2'b00};
    end
  endgenerate

  // Handshake and occupancy bookkeeping.
  always_comb begin
    pop_c        = out_valid & out_ready;
    full_c       = (count == FULL_CNT);
    enq_c        = !start_up & !redirect_valid & (!full_c | pop_c);
    target_c     = redirect_mode ? jmp_target_c : br_target_c;
    count_next_c = count;
    case ({enq_c, pop_c})
      2'b10:   count_next_c = count + CNT_W'(1);
      2'b01:   count_next_c = count - CNT_W'(1);
      default: count_next_c = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (start_up) begin
      pc        <= RESET_PC;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
    end else if (redirect_valid) begin
      // Flush discards everything, including a head decode was about to take.
      pc        <= target_c;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
    end else begin
      if (enq_c) begin
        pc     <= pc + ADDR_W'(4);
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
      end
      count     <= count_next_c;
      out_valid <= (count_next_c != '0);
    end
  end

  // Queue storage needs no reset; occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (enq_c) begin
      instr_mem[wr_ptr] <= imem_rdata;
      pc_mem[wr_ptr]    <= pc;
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (start_up) begin
      perf_fetched <= '0;
      perf_flushed <= '0;
      perf_stall   <= '0;
    end else begin
      if (enq_c) begin
        perf_fetched <= perf_fetched + 32'd1;
      end
      if (redirect_valid) begin
        perf_flushed <= perf_flushed + 32'(count);
      end
      if (full_c && !pop_c) begin
        perf_stall <= perf_stall + 32'd1;
      end
    end
  end
`endif

endmodule
